// File: rtl/cerradura_secuencial_pkg.sv
// Shared constants for the sequential code lock: digit width, state encoding
// and a small helper used to size the shared down-counter.
package cerradura_secuencial_pkg;

    localparam int DIGIT_W = 2;

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cerradura_secuencial_comparador.sv
// 2-bit equality comparator; checks the entered digit against the expected one.
module comparador
    import cerradura_secuencial_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic               aeqb
);

    assign aeqb = (a == b);

endmodule

// File: rtl/cerradura_secuencial.sv
// Sequential code lock: N_DIGITS digits checked against CODE, with unlock window,
// failure counting and lockout. Define CERRADURA_TIMEOUT_EN for the inter-digit timeout.
//
//  state      | meaning
//  ST_ENTRY   | collecting digits of an attempt
//  ST_OPEN    | correct code entered, unlocked for UNLOCK_CYCLES
//  ST_LOCKOUT | MAX_FAILS consecutive failures, inputs ignored for LOCKOUT_CYCLES
module cerradura_secuencial
    import cerradura_secuencial_pkg::*;
#(
    parameter int                    N_DIGITS       = 4,
    parameter logic [2*N_DIGITS-1:0] CODE           = 8'b11100100,
    parameter int                    UNLOCK_CYCLES  = 50_000_000,
    parameter int                    MAX_FAILS      = 3,
    parameter int                    LOCKOUT_CYCLES = 250_000_000,
    parameter int                    TIMEOUT_CYCLES = 500_000_000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [1:0]                       digit,
    input  logic                             digit_valid,
    input  logic                             clear,
    output logic                             unlocked,
    output logic                             error,
    output logic                             locked_out,
    output logic [$clog2(N_DIGITS+1)-1:0]    digit_count,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

    localparam int IW = $clog2(N_DIGITS + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
`ifdef CERRADURA_TIMEOUT_EN
    localparam int TMAX = max3(UNLOCK_CYCLES, LOCKOUT_CYCLES, TIMEOUT_CYCLES);
`else
    localparam int TMAX = max3(UNLOCK_CYCLES, LOCKOUT_CYCLES, 1);
`endif
    localparam int TW = $clog2(TMAX + 1);

    state_t              state;
    logic [IW-1:0]       idx;
    logic                mismatch;
    logic [TW-1:0]       tmr;
    logic [DIGIT_W-1:0]  code_digits [2**IW];
    logic                aeqb;
    logic                accept, last_digit, finish, bad, timeout, fail;
    logic [FW-1:0]       fail_next;

    // Table padded to a power of two so idx indexes it at its natural width.
    for (genvar k = 0; k < 2**IW; k++) begin : g_code
        if (k < N_DIGITS) begin : g_used
            assign code_digits[k] = CODE[DIGIT_W*k +: DIGIT_W];
        end else begin : g_pad
            assign code_digits[k] = '0;
        end
    end

    comparador u_comparador (
        .a    (digit),
        .b    (code_digits[idx]),
        .aeqb (aeqb)
    );

    assign accept     = (state == ST_ENTRY) && digit_valid && !clear;
    assign last_digit = (idx == IW'(N_DIGITS - 1));
    assign finish     = accept && last_digit;
    assign bad        = mismatch | ~aeqb;
`ifdef CERRADURA_TIMEOUT_EN
    assign timeout    = (state == ST_ENTRY) && !clear && !digit_valid
                        && (idx != '0) && (tmr == '0);
`else
    assign timeout    = 1'b0;
`endif
    assign fail       = (finish && bad) || timeout;
    assign fail_next  = (fail_count == FW'(MAX_FAILS)) ? fail_count : fail_count + 1'b1;
    assign digit_count = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ENTRY;
            idx        <= '0;
            mismatch   <= 1'b0;
            tmr        <= '0;
            fail_count <= '0;
            unlocked   <= 1'b0;
            error      <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            error <= 1'b0;
            case (state)
                ST_ENTRY: begin
                    if (clear) begin
                        idx      <= '0;
                        mismatch <= 1'b0;
                    end else if (fail) begin
                        idx        <= '0;
                        mismatch   <= 1'b0;
                        error      <= 1'b1;
                        fail_count <= fail_next;
                        if (fail_next == FW'(MAX_FAILS)) begin
                            state      <= ST_LOCKOUT;
                            locked_out <= 1'b1;
                            tmr        <= TW'(LOCKOUT_CYCLES - 1);
                        end
                    end else if (finish) begin
                        idx        <= '0;
                        mismatch   <= 1'b0;
                        fail_count <= '0;
                        state      <= ST_OPEN;
                        unlocked   <= 1'b1;
                        tmr        <= TW'(UNLOCK_CYCLES - 1);
                    end else if (accept) begin
                        idx      <= idx + 1'b1;
                        mismatch <= bad;
`ifdef CERRADURA_TIMEOUT_EN
                        tmr      <= TW'(TIMEOUT_CYCLES - 1);
                    end else if (idx != '0) begin
                        tmr      <= tmr - 1'b1;
`endif
                    end
                end
                ST_OPEN: begin
                    if (clear || tmr == '0) begin
                        state    <= ST_ENTRY;
                        unlocked <= 1'b0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (tmr == '0) begin
                        state      <= ST_ENTRY;
                        locked_out <= 1'b0;
                        fail_count <= '0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: begin
                    state      <= ST_ENTRY;
                    unlocked   <= 1'b0;
                    locked_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cerradura_secuencial.sv
// Bench for cerradura_secuencial: directed scenarios plus random strobes,
// every cycle compared against a digit-queue reference model.
module tb_cerradura_secuencial;

    localparam int N   = 4;
    localparam logic [7:0] CODE_V = 8'b11100100;
    localparam int U   = 4;
    localparam int L   = 8;
    localparam int MF  = 3;
    localparam int T   = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] digit = '0;
    logic       digit_valid = 1'b0;
    logic       clear = 1'b0;
    logic       unlocked, error, locked_out;
    logic [2:0] digit_count;
    logic [1:0] fail_count;

    int n_checks = 0;
    int n_fail   = 0;
    int hi_unl = 0, hi_err = 0, hi_lo = 0;

    cerradura_secuencial #(
        .N_DIGITS(N), .CODE(CODE_V), .UNLOCK_CYCLES(U), .MAX_FAILS(MF),
        .LOCKOUT_CYCLES(L), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digit(digit), .digit_valid(digit_valid),
        .clear(clear), .unlocked(unlocked), .error(error), .locked_out(locked_out),
        .digit_count(digit_count), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = taking digits, 1 = open, 2 = locked out
    int m_mode = 0;
    int q[$];
    int m_fails = 0, m_rem = 0, m_idle = 0;
    bit m_err = 0;

    function automatic int code_digit(input int k);
        return (int'(CODE_V) >> (2 * k)) & 3;
    endfunction

    task automatic model_reset();
        m_mode = 0; q.delete(); m_fails = 0; m_rem = 0; m_idle = 0; m_err = 0;
    endtask

    task automatic attempt_failed();
        m_err = 1;
        if (m_fails < MF) m_fails++;
        if (m_fails == MF) begin m_mode = 2; m_rem = L; end
    endtask

    task automatic model_step();
        bit ok;
        m_err = 0;
        case (m_mode)
            0: begin
                if (clear) begin
                    q.delete(); m_idle = 0;
                end else if (digit_valid) begin
                    q.push_back(int'(digit)); m_idle = 0;
                    if (q.size() == N) begin
                        ok = 1;
                        for (int k = 0; k < N; k++) if (q[k] != code_digit(k)) ok = 0;
                        q.delete();
                        if (ok) begin m_mode = 1; m_rem = U; m_fails = 0; end
                        else attempt_failed();
                    end
`ifdef CERRADURA_TIMEOUT_EN
                end else if (q.size() > 0) begin
                    m_idle++;
                    if (m_idle == T) begin q.delete(); m_idle = 0; attempt_failed(); end
`endif
                end
            end
            1: begin
                m_rem--;
                if (clear || m_rem == 0) m_mode = 0;
            end
            default: begin
                m_rem--;
                if (m_rem == 0) begin m_mode = 0; m_fails = 0; end
            end
        endcase
    endtask

    always @(posedge clk) if (rst_n) model_step();

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("unlocked",    int'(unlocked),    int'(m_mode == 1));
        check("locked_out",  int'(locked_out),  int'(m_mode == 2));
        check("error",       int'(error),       int'(m_err));
        check("digit_count", int'(digit_count), q.size());
        check("fail_count",  int'(fail_count),  m_fails);
        if (unlocked)   hi_unl++;
        if (error)      hi_err++;
        if (locked_out) hi_lo++;
    endtask

    task automatic tick(input bit v, input int d, input bit c);
        @(negedge clk);
        compare_all();
        digit_valid = v; digit = 2'(d); clear = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0);
    endtask

    task automatic enter4(input int d0, input int d1, input int d2, input int d3);
        tick(1, d0, 0); tick(1, d1, 0); tick(1, d2, 0); tick(1, d3, 0);
        tick(0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        compare_all();
        digit_valid = 0; clear = 0; rst_n = 0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        int exp_d;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1;

        // correct code
        hi_unl = 0; hi_err = 0;
        enter4(0, 1, 2, 3);
        idle(8);
        check("s1_unlock_cycles", hi_unl, U);
        check("s1_no_error", hi_err, 0);

        // wrong third digit
        hi_err = 0; hi_unl = 0;
        enter4(0, 1, 3, 3);
        idle(2);
        check("s2_error_cycles", hi_err, 1);
        check("s2_fail_count", int'(fail_count), 1);
        check("s2_not_unlocked", hi_unl, 0);

        // three consecutive wrong attempts -> lockout, strobes ignored
        do_reset();
        hi_lo = 0;
        enter4(3, 3, 3, 3);
        enter4(0, 1, 2, 0);
        tick(1, 1, 0); tick(1, 1, 0); tick(1, 1, 0); tick(1, 1, 0);
        for (int i = 0; i < 6; i++) tick(1, i % 4, 1);
        idle(8);
        check("s3_lockout_cycles", hi_lo, L);
        check("s3_fail_cleared", int'(fail_count), 0);
        hi_unl = 0;
        enter4(0, 1, 2, 3);
        idle(5);
        check("s3_unlock_after", hi_unl, U);

        // clear together with a digit strobe
        enter4(1, 1, 1, 1);
        tick(1, 0, 0); tick(1, 1, 0); tick(1, 2, 1); tick(0, 0, 0);
        check("s4_count_cleared", int'(digit_count), 0);
        check("s4_fail_kept", int'(fail_count), 1);
        hi_unl = 0;
        enter4(0, 1, 2, 3);
        idle(5);
        check("s4_unlock", hi_unl, U);

        // clear during OPEN
        hi_unl = 0;
        enter4(0, 1, 2, 3);
        tick(0, 0, 1); tick(0, 0, 0); idle(3);
        check("open_clear_cycles", hi_unl, 2);

        // async reset mid-entry and mid-open
        tick(1, 0, 0); tick(1, 1, 0); tick(0, 0, 0);
        check("s5_mid_count", int'(digit_count), 2);
        do_reset();
        check("s5_count_zero", int'(digit_count), 0);
        enter4(0, 1, 2, 3);
        tick(0, 0, 0);
        check("s5_open_before", int'(unlocked), 1);
        do_reset();
        check("s5_open_reset", int'(unlocked), 0);

        // inter-digit timeout
        hi_err = 0;
        tick(1, 0, 0);
        idle(8);
`ifdef CERRADURA_TIMEOUT_EN
        check("s6_timeout_error", hi_err, 1);
`else
        check("s6_no_timeout", hi_err, 0);
        tick(0, 0, 1); tick(0, 0, 0);
`endif

        // random traffic biased toward the correct digits
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 70) exp_d = code_digit(q.size() % N);
            else exp_d = int'($urandom_range(0, 3));
            tick($urandom_range(0, 99) < 45, exp_d, $urandom_range(0, 99) < 4);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
